// File: rtl/layer6_pool_sequencer_pkg.sv
// Shared definitions for the layer-6 pooling sequencer.
// Holds the FSM state encoding, the engine coordinate word length, layer-6 default geometry
// and the per-group base-offset helpers used by the address mappers.
package layer6_pool_sequencer_pkg;

  // Width of the row/col coordinate words coming from the pooling engine.
  localparam int unsigned WORDLENGTH = 16;

  // Layer-6 default geometry.
  localparam int unsigned L6InWidth  = 16;
  localparam int unsigned L6ChGroups = 4;

  // Distance between consecutive channel groups in the pixel and output SRAMs.
  localparam int unsigned L6PixGroupStride = L6InWidth * L6InWidth;
  localparam int unsigned L6OutGroupStride = (L6InWidth / 2) * (L6InWidth / 2);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StRun,
    StGap,
    StDone
  } pool_state_e;

  // Linear offset of channel group grp inside a bank of side x side maps.
  function automatic int unsigned group_base(input int unsigned grp, input int unsigned side);
    return grp * side * side;
  endfunction

endpackage

// File: rtl/layer6_pool_sequencer_addr_map.sv
// layer_addr_map: combinational row/col to linear SRAM address mapper.
//   en_i    : address is driven only while enabled, otherwise 0
//   row_i   : map row coordinate
//   col_i   : map column coordinate
//   base_i  : linear base of the current channel group
//   addr_o  : base_i + row_i*Width + col_i, truncated to AddrW
module layer_addr_map
  import layer6_pool_sequencer_pkg::*;
#(
  parameter int unsigned Width = 16,
  parameter int unsigned AddrW = 16
) (
  input  logic                  en_i,
  input  logic [WORDLENGTH-1:0] row_i,
  input  logic [WORDLENGTH-1:0] col_i,
  input  logic [AddrW-1:0]      base_i,
  output logic [AddrW-1:0]      addr_o
);

  // Arithmetic at AddrW bits gives exactly the truncated full-precision result.
  always_comb begin
    addr_o = '0;
    if (en_i) begin
      addr_o = base_i + AddrW'(row_i) * AddrW'(Width) + AddrW'(col_i);
    end
  end

endmodule

// File: rtl/layer6_pool_sequencer.sv
// layer6_pool_sequencer: starts the 2x2 max-pooling engine once per channel group, maps the
// engine's read/save coordinates to linear pixel/output SRAM addresses, counts committed writes
// per group and handshakes with layer 5 (producer) and layer 7 (consumer).
//   clk, rst               : clock, asynchronous active-high reset
//   layer5_done            : one-cycle pulse, input map stored (queued if not idle)
//   layer7_ack             : downstream took the results (honoured only in DONE)
//   pool_start             : one-cycle engine start per group
//   pool_read_*, pool_save_enable, pool_output_*, pool_done : engine interface
//   pix_rd_en/addr, out_wr_en/addr : SRAM ports, live only while running
//   group_idx              : current channel group
//   busy, layer6_done      : status towards the system
//   wr_count_err           : sticky, some group committed a wrong number of writes
module layer6_pool_sequencer
  import layer6_pool_sequencer_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = L6InWidth,
  parameter int unsigned OUT_WIDTH = IN_WIDTH / 2,
  parameter int unsigned CH_GROUPS = L6ChGroups,
  parameter int unsigned ADDR_W    = 16,
  localparam int unsigned GroupW   = (CH_GROUPS > 1) ? $clog2(CH_GROUPS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  layer5_done,
  input  logic                  layer7_ack,
  output logic                  pool_start,
  input  logic                  pool_read_signal,
  input  logic [WORDLENGTH-1:0] pool_read_row,
  input  logic [WORDLENGTH-1:0] pool_read_col,
  input  logic                  pool_save_enable,
  input  logic [WORDLENGTH-1:0] pool_output_row,
  input  logic [WORDLENGTH-1:0] pool_output_col,
  input  logic                  pool_done,
  output logic                  pix_rd_en,
  output logic [ADDR_W-1:0]     pix_rd_addr,
  output logic                  out_wr_en,
  output logic [ADDR_W-1:0]     out_wr_addr,
  output logic [GroupW-1:0]     group_idx,
  output logic                  busy,
  output logic                  layer6_done,
  output logic                  wr_count_err
);

  localparam int unsigned OutPix = OUT_WIDTH * OUT_WIDTH;
  // One spare bit so an overrun can never alias back onto OutPix.
  localparam int unsigned CntW   = $clog2(OutPix + 2) + 1;

  pool_state_e       state_q, state_d;
  logic [GroupW-1:0] group_q, group_d;
  logic [CntW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [CntW-1:0]   wr_total;
  logic              pend_q, pend_d;
  logic              err_q, err_d;
  logic              run;
  logic [ADDR_W-1:0] pix_base;
  logic [ADDR_W-1:0] out_base;

  always_comb begin
    state_d  = state_q;
    group_d  = group_q;
    wr_cnt_d = wr_cnt_q;
    pend_d   = pend_q;
    err_d    = err_q;
    // The last write may land in the same cycle as pool_done, so it is part of the total.
    wr_total = wr_cnt_q + CntW'(pool_save_enable);

    unique case (state_q)
      StIdle: begin
        if (layer5_done || pend_q) begin
          state_d = StStart;
          pend_d  = 1'b0;
          group_d = '0;
          err_d   = 1'b0;
        end
      end
      StStart: begin
        wr_cnt_d = '0;
        state_d  = StRun;
      end
      StRun: begin
        if (pool_save_enable && (wr_cnt_q != '1)) begin
          wr_cnt_d = wr_cnt_q + 1'b1;
        end
        if (pool_done) begin
          if (wr_total != CntW'(OutPix)) begin
            err_d = 1'b1;
          end
          if (group_q == GroupW'(CH_GROUPS - 1)) begin
            state_d = StDone;
          end else begin
            group_d = group_q + 1'b1;
            state_d = StGap;
          end
        end
      end
      StGap:  state_d = StStart;
      StDone: begin
        if (layer7_ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A new map announced while busy is replayed once we are back in IDLE.
    if (layer5_done && (state_q != StIdle)) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      group_q  <= '0;
      wr_cnt_q <= '0;
      pend_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      group_q  <= group_d;
      wr_cnt_q <= wr_cnt_d;
      pend_q   <= pend_d;
      err_q    <= err_d;
    end
  end

  assign run      = (state_q == StRun);
  assign pix_base = ADDR_W'(group_base(32'(group_q), IN_WIDTH));
  assign out_base = ADDR_W'(group_base(32'(group_q), OUT_WIDTH));

  layer_addr_map #(
    .Width (IN_WIDTH),
    .AddrW (ADDR_W)
  ) u_rd_map (
    .en_i   (run),
    .row_i  (pool_read_row),
    .col_i  (pool_read_col),
    .base_i (pix_base),
    .addr_o (pix_rd_addr)
  );

  layer_addr_map #(
    .Width (OUT_WIDTH),
    .AddrW (ADDR_W)
  ) u_wr_map (
    .en_i   (run),
    .row_i  (pool_output_row),
    .col_i  (pool_output_col),
    .base_i (out_base),
    .addr_o (out_wr_addr)
  );

  assign pix_rd_en    = run & pool_read_signal;
  assign out_wr_en    = run & pool_save_enable;
  assign pool_start   = (state_q == StStart);
  assign busy         = (state_q != StIdle);
  assign layer6_done  = (state_q == StDone);
  assign group_idx    = group_q;
  assign wr_count_err = err_q;

endmodule

// File: tb/tb_layer6_pool_sequencer.sv
// Self-checking bench for layer6_pool_sequencer with default parameters (16x16 in, 4 groups).
module tb_layer6_pool_sequencer;

  logic        clk;
  logic        rst;
  logic        layer5_done;
  logic        layer7_ack;
  logic        pool_start;
  logic        pool_read_signal;
  logic [15:0] pool_read_row;
  logic [15:0] pool_read_col;
  logic        pool_save_enable;
  logic [15:0] pool_output_row;
  logic [15:0] pool_output_col;
  logic        pool_done;
  logic        pix_rd_en;
  logic [15:0] pix_rd_addr;
  logic        out_wr_en;
  logic [15:0] out_wr_addr;
  logic [1:0]  group_idx;
  logic        busy;
  logic        layer6_done;
  logic        wr_count_err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int grp;
    bit rd;
    int row;
    int col;
    bit exp_en;
    int exp_addr;
  } vec_t;

  vec_t vecs[6];

  layer6_pool_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .layer5_done      (layer5_done),
    .layer7_ack       (layer7_ack),
    .pool_start       (pool_start),
    .pool_read_signal (pool_read_signal),
    .pool_read_row    (pool_read_row),
    .pool_read_col    (pool_read_col),
    .pool_save_enable (pool_save_enable),
    .pool_output_row  (pool_output_row),
    .pool_output_col  (pool_output_col),
    .pool_done        (pool_done),
    .pix_rd_en        (pix_rd_en),
    .pix_rd_addr      (pix_rd_addr),
    .out_wr_en        (out_wr_en),
    .out_wr_addr      (out_wr_addr),
    .group_idx        (group_idx),
    .busy             (busy),
    .layer6_done      (layer6_done),
    .wr_count_err     (wr_count_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 ns after the rising edge, outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_engine();
    pool_read_signal = 1'b0;
    pool_read_row    = '0;
    pool_read_col    = '0;
    pool_save_enable = 1'b0;
    pool_output_row  = '0;
    pool_output_col  = '0;
    pool_done        = 1'b0;
  endtask

  // layer5_done pulse in an IDLE cycle; returns in the START cycle that follows.
  task automatic kick();
    step();
    layer5_done = 1'b1;
    settle();
    chk("kick_idle_no_start", pool_start, 0);
    chk("kick_idle_busy", busy, 0);
    step();
    layer5_done = 1'b0;
    settle();
    chk("kick_start", pool_start, 1);
  endtask

  // Engine model for one full pass over all groups; entered in the START cycle of group 0.
  task automatic run_groups(input int skip_grp, input int pend_grp, input int rst_grp);
    int nw;
    bit exp_err;
    for (int g = 0; g < 4; g++) begin
      chk("start_pulse", pool_start, 1);
      chk("start_group", group_idx, g);
      chk("start_busy", busy, 1);
      step();
      if (g == rst_grp) begin
        pool_read_signal = 1'b1;
        pool_read_row    = 16'd2;
        pool_read_col    = 16'd3;
        pool_save_enable = 1'b1;
        settle();
        chk("pre_rst_rd_addr", pix_rd_addr, g * 256 + 2 * 16 + 3);
        rst = 1'b1;
        #1;
        chk("rst_rd_en", pix_rd_en, 0);
        chk("rst_rd_addr", pix_rd_addr, 0);
        chk("rst_wr_en", out_wr_en, 0);
        chk("rst_wr_addr", out_wr_addr, 0);
        chk("rst_start", pool_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", layer6_done, 0);
        chk("rst_group", group_idx, 0);
        chk("rst_err", wr_count_err, 0);
        clear_engine();
        return;
      end
      chk("run_no_start", pool_start, 0);
      foreach (vecs[i]) begin
        if (vecs[i].grp == g) begin
          pool_read_signal = vecs[i].rd;
          pool_read_row    = 16'(vecs[i].row);
          pool_read_col    = 16'(vecs[i].col);
          pool_save_enable = 1'b0;
          settle();
          chk("map_rd_en", pix_rd_en, vecs[i].exp_en);
          if (vecs[i].exp_en) chk("map_rd_addr", pix_rd_addr, vecs[i].exp_addr);
          chk("map_no_wr", out_wr_en, 0);
          step();
        end
      end
      nw = (g == skip_grp) ? 63 : 64;
      for (int k = 0; k < nw; k++) begin
        pool_read_signal = 1'b1;
        pool_read_row    = 16'(2 * (k / 8));
        pool_read_col    = 16'(2 * (k % 8));
        pool_save_enable = 1'b1;
        pool_output_row  = 16'(k / 8);
        pool_output_col  = 16'(k % 8);
        pool_done        = (k == nw - 1);
        layer5_done      = (g == pend_grp) && (k == 0);
        settle();
        chk("wr_en", out_wr_en, 1);
        chk("wr_addr", out_wr_addr, g * 64 + k);
        chk("rd_addr", pix_rd_addr, g * 256 + 2 * (k / 8) * 16 + 2 * (k % 8));
        step();
      end
      clear_engine();
      layer5_done = 1'b0;
      exp_err = (skip_grp >= 0) && (g >= skip_grp);
      if (g < 3) begin
        // Engine noise and a stray ack during GAP must be ignored.
        pool_read_signal = 1'b1;
        pool_save_enable = 1'b1;
        pool_done        = 1'b1;
        layer7_ack       = 1'b1;
        settle();
        chk("gap_rd_en", pix_rd_en, 0);
        chk("gap_wr_en", out_wr_en, 0);
        chk("gap_rd_addr", pix_rd_addr, 0);
        chk("gap_no_start", pool_start, 0);
        chk("gap_busy", busy, 1);
        chk("gap_not_done", layer6_done, 0);
        chk("gap_group", group_idx, g + 1);
        chk("gap_err", wr_count_err, exp_err);
        step();
        clear_engine();
        layer7_ack = 1'b0;
        settle();
      end else begin
        settle();
        chk("done_flag", layer6_done, 1);
        chk("done_busy", busy, 1);
        chk("done_err", wr_count_err, exp_err);
        chk("done_rd_en", pix_rd_en, 0);
      end
    end
  endtask

  initial begin
    vecs[0] = '{0, 1'b1, 0, 0, 1'b1, 0};
    vecs[1] = '{1, 1'b1, 7, 2, 1'b1, 370};
    vecs[2] = '{1, 1'b1, 0, 15, 1'b1, 271};
    vecs[3] = '{2, 1'b1, 3, 5, 1'b1, 565};
    vecs[4] = '{2, 1'b0, 3, 5, 1'b0, 0};
    vecs[5] = '{3, 1'b1, 15, 15, 1'b1, 1023};

    rst         = 1'b1;
    layer5_done = 1'b0;
    layer7_ack  = 1'b0;
    clear_engine();
    step();
    step();
    chk("reset_start", pool_start, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", layer6_done, 0);
    chk("reset_rd_en", pix_rd_en, 0);
    chk("reset_wr_en", out_wr_en, 0);
    chk("reset_group", group_idx, 0);
    chk("reset_err", wr_count_err, 0);
    rst = 1'b0;
    repeat (3) begin
      step();
      settle();
      chk("idle_no_start", pool_start, 0);
    end

    // Run 1: clean pass, then hold ack low in DONE.
    kick();
    run_groups(-1, -1, -1);
    for (int i = 0; i < 20; i++) begin
      step();
      settle();
      chk("hold_done", layer6_done, 1);
      chk("hold_busy", busy, 1);
      chk("hold_no_start", pool_start, 0);
    end
    step();
    layer7_ack = 1'b1;
    settle();
    chk("ack_cycle_done", layer6_done, 1);
    step();
    layer7_ack = 1'b0;
    settle();
    chk("ack_idle_done", layer6_done, 0);
    chk("ack_idle_busy", busy, 0);
    repeat (3) begin
      step();
      settle();
      chk("idle_wait_no_start", pool_start, 0);
    end

    // Run 2: group 1 short by one write, layer5_done queued during group 3.
    kick();
    run_groups(1, 3, -1);
    step();
    layer7_ack = 1'b1;
    settle();
    step();
    layer7_ack = 1'b0;
    settle();
    chk("auto_idle_busy", busy, 0);
    chk("auto_idle_start", pool_start, 0);
    chk("auto_idle_err", wr_count_err, 1);
    step();
    settle();
    chk("auto_err_clear", wr_count_err, 0);

    // Run 3: automatic restart, then reset in the middle of group 1.
    run_groups(-1, -1, 1);
    step();
    rst = 1'b0;
    pool_read_signal = 1'b1;
    repeat (5) begin
      step();
      settle();
      chk("post_rst_no_start", pool_start, 0);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_rd_en", pix_rd_en, 0);
    end
    clear_engine();
    kick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
